// File: rtl/var_delay_buffer.sv
// Multi-lane beat-counted delay line with runtime delay 1..2**ADDR_WIDTH; output registered, 1 clk after the beat.
// Optional VAR_DELAY_ZERO_FILL_EN: emit zero lanes on every unprimed beat instead of gating out_en.
module var_delay_buffer #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_en,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic                        delay_load,
  input  logic [ADDR_WIDTH:0]         delay_sel,
  output logic                        out_en,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic                        cfg_err
);

  localparam int DW        = CHANNELS * WIDTH;
  localparam int MAX_DELAY = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_D = (ADDR_WIDTH+1)'(MAX_DELAY);

  logic [DW-1:0]         mem [MAX_DELAY];
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [ADDR_WIDTH:0]   d_q, d_d;
  logic                  out_en_q, out_en_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  load_ok, load_bad, primed, emit;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DW-1:0]         rd_word;

  always_comb begin
    load_ok  = delay_load && (delay_sel != '0) && (delay_sel <= MAX_D);
    load_bad = delay_load && !load_ok;
    primed   = (fill_q >= d_q);
    // d = MAX_DELAY drops to 0 in the low bits, so read and write share an address
    rd_addr  = w_addr_q - d_q[ADDR_WIDTH-1:0];
    rd_word  = mem[rd_addr];
    // a legal load restarts the fill, so the beat that carries it is never primed
    emit     = primed && !load_ok;

    w_addr_d   = w_addr_q;
    fill_d     = fill_q;
    d_d        = d_q;
    cfg_err_d  = cfg_err_q;
    out_data_d = out_data_q;

    if (in_en) w_addr_d = w_addr_q + 1'b1;
    if (in_en && (fill_q != MAX_D)) fill_d = fill_q + 1'b1;
    if (load_ok) begin
      d_d    = delay_sel;
      fill_d = {{ADDR_WIDTH{1'b0}}, in_en};
    end
    if (load_bad) cfg_err_d = 1'b1;

`ifdef VAR_DELAY_ZERO_FILL_EN
    out_en_d = in_en;
    if (in_en) out_data_d = emit ? rd_word : '0;
`else
    out_en_d = in_en && emit;
    if (in_en && emit) out_data_d = rd_word;
`endif
  end

  // Storage is deliberately not reset; fill gating hides stale contents.
  always_ff @(posedge clock) begin
    if (in_en) mem[w_addr_q] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr_q   <= '0;
      fill_q     <= '0;
      d_q        <= MAX_D;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      w_addr_q   <= w_addr_d;
      fill_q     <= fill_d;
      d_q        <= d_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign out_en   = out_en_q;
  assign out_data = out_data_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_var_delay_buffer.sv
// Directed bench for var_delay_buffer: fill latency, reload, gaps, illegal loads, wrap and mid-stream reset.
module tb_var_delay_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_en;
  logic [31:0] in_data;
  logic        delay_load;
  logic [6:0]  delay_sel;
  logic        out_en;
  logic [31:0] out_data;
  logic        cfg_err;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_data;

  var_delay_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .in_en      (in_en),
    .in_data    (in_data),
    .delay_load (delay_load),
    .delay_sel  (delay_sel),
    .out_en     (out_en),
    .out_data   (out_data),
    .cfg_err    (cfg_err)
  );

  always #5 clock = ~clock;

  // lane0 = n, lane1 = n + 0x100
  function automatic logic [31:0] word(input int n);
    return {16'(n + 256), 16'(n)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input int n, input logic ld, input logic [6:0] sel);
    in_en      = en;
    in_data    = en ? word(n) : 32'h0;
    delay_load = ld;
    delay_sel  = sel;
    @(posedge clock);
    #1;
    in_en      = 1'b0;
    delay_load = 1'b0;
  endtask

  // Check the registered output after one in_en beat.
  task automatic chk_beat(input string tag, input int i, input bit primed,
                          input logic [31:0] w, input bit zero_chk);
`ifdef VAR_DELAY_ZERO_FILL_EN
    chk($sformatf("%s[%0d].en", tag, i), {31'b0, out_en}, 32'd1);
    if (primed) chk($sformatf("%s[%0d].dat", tag, i), out_data, w);
    else        chk($sformatf("%s[%0d].zero", tag, i), out_data, 32'h0);
    last_data = primed ? w : 32'h0;
`else
    chk($sformatf("%s[%0d].en", tag, i), {31'b0, out_en}, {31'b0, primed});
    if (primed) begin
      chk($sformatf("%s[%0d].dat", tag, i), out_data, w);
      last_data = w;
    end else if (zero_chk) begin
      chk($sformatf("%s[%0d].zero", tag, i), out_data, 32'h0);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; in_en = 1'b0; in_data = '0; delay_load = 1'b0; delay_sel = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.en",  {31'b0, out_en},  32'd0);
    chk("rst.dat", out_data,         32'h0);
    chk("rst.err", {31'b0, cfg_err}, 32'd0);
    reset = 1'b0;
    last_data = 32'h0;

    // default delay 64: first output after beat 64 carries sample 0
    for (int i = 0; i < 70; i++) begin
      step(1'b1, i, 1'b0, 7'd0);
      chk_beat("t1", i, i >= 64, word(i - 64), 1'b1);
    end

    // load d=5 on an idle cycle
    step(1'b0, 0, 1'b1, 7'd5);
    chk("t2.load.en", {31'b0, out_en}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 200 + i, 1'b0, 7'd0);
      chk_beat("t2", i, i >= 5, word(195 + i), 1'b0);
    end

    // d=3 with alternating gaps: delay counts beats, not clocks
    step(1'b0, 0, 1'b1, 7'd3);
    chk("t3.load.en",  {31'b0, out_en}, 32'd0);
    chk("t3.load.dat", out_data, last_data);
    begin
      int k = 0;
      for (int c = 0; c < 16; c++) begin
        if (c % 2 == 0) begin
          step(1'b1, 300 + k, 1'b0, 7'd0);
          chk_beat("t3", k, k >= 3, word(297 + k), 1'b0);
          k++;
        end else begin
          step(1'b0, 0, 1'b0, 7'd0);
          chk($sformatf("t3.idle[%0d].en", c),  {31'b0, out_en}, 32'd0);
          chk($sformatf("t3.idle[%0d].dat", c), out_data, last_data);
        end
      end
    end

    // run at d=4, then reload d=8 on a live beat (beat counts as first of new delay)
    step(1'b0, 0, 1'b1, 7'd4);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 400 + i, 1'b0, 7'd0);
      chk_beat("t4a", i, i >= 4, word(396 + i), 1'b0);
    end
    for (int j = 0; j < 15; j++) begin
      step(1'b1, 500 + j, j == 0, 7'd8);
      chk_beat("t4b", j, j >= 8, word(492 + j), 1'b0);
    end

    // illegal loads set the sticky error and leave the stream untouched
    step(1'b1, 515, 1'b1, 7'd0);
    chk_beat("t5", 15, 1'b1, word(507), 1'b0);
    chk("t5.err0", {31'b0, cfg_err}, 32'd1);
    step(1'b1, 516, 1'b1, 7'd65);
    chk_beat("t5", 16, 1'b1, word(508), 1'b0);
    chk("t5.err65", {31'b0, cfg_err}, 32'd1);
    for (int j = 17; j < 20; j++) begin
      step(1'b1, 500 + j, 1'b0, 7'd0);
      chk_beat("t5", j, 1'b1, word(492 + j), 1'b0);
      chk($sformatf("t5.err[%0d]", j), {31'b0, cfg_err}, 32'd1);
    end

    // d=64 across the address wrap
    step(1'b0, 0, 1'b1, 7'd64);
    chk("t6.load.err", {31'b0, cfg_err}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 600 + i, 1'b0, 7'd0);
      chk_beat("t6", i, i >= 64, word(536 + i), 1'b0);
    end

    // mid-stream reset discards contents and the error flag
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t6.rst.en",  {31'b0, out_en},  32'd0);
    chk("t6.rst.dat", out_data,         32'h0);
    chk("t6.rst.err", {31'b0, cfg_err}, 32'd0);
    for (int i = 0; i < 66; i++) begin
      step(1'b1, 800 + i, 1'b0, 7'd0);
      chk_beat("t6r", i, i >= 64, word(736 + i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
